// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared definitions for the MIPS32 pipeline control unit:
//                stall-bus type, the four priority stall encodings, the
//                idle encoding, the default exception vector and a helper
//                that resolves per-stage stall requests into a stall vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Stall vector: bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB,
    // 5 = WB (never stalled).
    typedef logic [5:0] StallBus;

    localparam StallBus StallMem = 6'b011111;
    localparam StallBus StallEx  = 6'b001111;
    localparam StallBus StallId  = 6'b000111;
    localparam StallBus StallIf  = 6'b000011;
    localparam StallBus NoStall  = 6'b000000;

    localparam logic [31:0] ExcVectorDefault = 32'h0000_0020;

    // A stall in a later stage must also freeze every earlier stage, so the
    // deepest requesting stage decides the whole vector.
    function automatic StallBus stall_encode(
        input logic req_mem,
        input logic req_ex,
        input logic req_id,
        input logic req_if
    );
        if (req_mem) begin
            return StallMem;
        end else if (req_ex) begin
            return StallEx;
        end else if (req_id) begin
            return StallId;
        end else if (req_if) begin
            return StallIf;
        end
        return NoStall;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_perf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_perf
//  Description : Stall watchdog and performance counters for pipe_ctrl.
//                - run counter of consecutive PC-stall cycles, saturating at
//                  STALL_LIMIT; sets a sticky timeout flag when it gets there
//                - stall-cycle and flush counters, wrapping, with a
//                  synchronous clear that has priority over increment
//  Ports       : clk, rst (async, active-low)
//                i_stall_pc      - stall[0] of the current cycle
//                i_flush         - accepted flush this cycle
//                i_cnt_clr       - synchronous clear of both counters
//                o_stall_timeout - sticky watchdog flag (cleared by rst only)
//                o_stall_cycles  - count of cycles with stall[0]=1
//                o_flush_count   - count of accepted flushes
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_perf #(
    parameter int STALL_LIMIT = 1024,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall_pc,
    input  logic             i_flush,
    input  logic             i_cnt_clr,
    output logic             o_stall_timeout,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam int RW = $clog2(STALL_LIMIT + 1);
    localparam logic [RW-1:0] c_run_limit = RW'(STALL_LIMIT);
    localparam logic [RW-1:0] c_run_last  = RW'(STALL_LIMIT - 1);

    logic [RW-1:0]    r_run_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    // Watchdog: the edge that brings the run to STALL_LIMIT is the edge that
    // raises the flag, hence the compare against LIMIT-1 before incrementing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_cnt <= '0;
            r_timeout <= 1'b0;
        end else if (i_stall_pc) begin
            if (r_run_cnt >= c_run_last) begin
                r_run_cnt <= c_run_limit;
                r_timeout <= 1'b1;
            end else begin
                r_run_cnt <= r_run_cnt + RW'(1);
            end
        end else begin
            r_run_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else if (i_cnt_clr) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (i_stall_pc) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (i_flush) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign o_stall_timeout = r_timeout;
    assign o_stall_cycles  = r_stall_cycles;
    assign o_flush_count   = r_flush_count;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline control unit for the 5-stage MIPS32 core. Merges
//                stage stall requests into the stall vector, sequences
//                exception / ERET flushes through a RUN/DRAIN state machine,
//                supplies the redirect PC and hosts the stall watchdog and
//                performance counters.
//  Ports       : clk, rst (async, active-low)
//                stallreq_if/id/ex/mem - per-stage stall requests
//                excp_valid, excp_eret - exception / ERET from MEM stage
//                epc_i                 - ERET return address
//                cnt_clr               - clear performance counters
//                stall[5:0], flush, new_pc - combinational control outputs
//                stall_timeout, stall_cycles, flush_count - debug outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 2,
    parameter int          STALL_LIMIT  = 1024,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] EXC_VECTOR   = ExcVectorDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic             excp_eret,
    input  logic [31:0]      epc_i,
    input  logic             cnt_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Drain counter holds DRAIN_CYCLES-1 down to 0; keep at least one bit.
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] c_drain_load = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_drain_cnt;
    logic [DW-1:0] w_drain_nxt;
    StallBus       w_req_stall;
    StallBus       w_stall;
    logic          w_flush;
    logic [31:0]   w_new_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Outputs are held at zero while reset is asserted, so downstream stages
    // see neither a stall nor a flush during reset.
    always_comb begin
        w_req_stall = stall_encode(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_stall     = NoStall;
        w_flush     = 1'b0;
        w_new_pc    = '0;
        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    if (excp_valid) begin
                        // Flush wins over any stall request this cycle.
                        w_flush     = 1'b1;
                        w_new_pc    = excp_eret ? epc_i : EXC_VECTOR;
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = c_drain_load;
                    end else begin
                        w_stall = w_req_stall;
                    end
                end
                ST_DRAIN: begin
                    // Exceptions are masked while the flushed pipe refills.
                    w_stall = w_req_stall;
                    if (r_drain_cnt == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_drain_nxt = r_drain_cnt - DW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign stall  = w_stall;
    assign flush  = w_flush;
    assign new_pc = w_new_pc;

    pipe_ctrl_perf #(
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (CNT_W)
    ) u_perf (
        .clk             (clk),
        .rst             (rst),
        .i_stall_pc      (w_stall[0]),
        .i_flush         (w_flush),
        .i_cnt_clr       (cnt_clr),
        .o_stall_timeout (stall_timeout),
        .o_stall_cycles  (stall_cycles),
        .o_flush_count   (flush_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl (DRAIN_CYCLES=2,
//                STALL_LIMIT=8, CNT_W=4). Each row of stimulus pushes its
//                expected outputs onto a scoreboard; the rows are replayed one
//                per clock and the scoreboard entries popped and compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid, excp_eret;
    logic [31:0] epc_i;
    logic        cnt_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [3:0]  stall_cycles;
    logic [3:0]  flush_count;

    pipe_ctrl #(
        .DRAIN_CYCLES (2),
        .STALL_LIMIT  (8),
        .CNT_W        (4),
        .EXC_VECTOR   (32'h0000_0020)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excp_valid    (excp_valid),
        .excp_eret     (excp_eret),
        .epc_i         (epc_i),
        .cnt_clr       (cnt_clr),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rq = {mem, ex, id, if}
    typedef struct packed {
        logic        r;
        logic [3:0]  rq;
        logic        ev;
        logic        er;
        logic [31:0] epc;
        logic        clr;
    } stim_t;

    typedef struct packed {
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic [3:0]  sc;
        logic [3:0]  fc;
        logic        to;
    } exp_t;

    stim_t sq[$];
    exp_t  eq[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference state for the counters/watchdog, advanced from the expected
    // stall[0]/flush of each row.
    logic [3:0] m_sc = '0;
    logic [3:0] m_fc = '0;
    int         m_run = 0;
    logic       m_to = 1'b0;

    task automatic row(input logic r, input logic [3:0] rq, input logic ev,
                       input logic er, input logic [31:0] epc, input logic clr,
                       input logic [5:0] st, input logic fl, input logic [31:0] pc);
        stim_t s;
        exp_t  e;
        s = '{r: r, rq: rq, ev: ev, er: er, epc: epc, clr: clr};
        if (!r) begin
            m_sc = '0; m_fc = '0; m_run = 0; m_to = 1'b0;
            e = '0;
        end else begin
            e = '{st: st, fl: fl, pc: pc, sc: m_sc, fc: m_fc, to: m_to};
            if (clr) begin
                m_sc = '0;
                m_fc = '0;
            end else begin
                m_sc = m_sc + {3'b000, st[0]};
                m_fc = m_fc + {3'b000, fl};
            end
            if (st[0]) begin
                if (m_run >= 7) begin
                    m_run = 8;
                    m_to  = 1'b1;
                end else begin
                    m_run = m_run + 1;
                end
            end else begin
                m_run = 0;
            end
        end
        sq.push_back(s);
        eq.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        rst          = s.r;
        stallreq_mem = s.rq[3];
        stallreq_ex  = s.rq[2];
        stallreq_id  = s.rq[1];
        stallreq_if  = s.rq[0];
        excp_valid   = s.ev;
        excp_eret    = s.er;
        epc_i        = s.epc;
        cnt_clr      = s.clr;
    endtask

    task automatic test_reset();
        exp_t e;
        int   k = 0;
        for (int i = 0; i < 3; i++) row(0, 4'hF, 1, 1, 32'h1234_5678, 0, 6'h00, 0, 32'h0);
        for (int i = 0; i < 2; i++) row(1, 4'h0, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0);
        while (sq.size() != 0) begin
            @(posedge clk); #1; apply(sq.pop_front());
            @(negedge clk); e = eq.pop_front(); n_tests++;
            if ({stall, flush, new_pc, stall_cycles, flush_count, stall_timeout} !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b, want stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b",
                         k, stall, flush, new_pc, stall_cycles, flush_count, stall_timeout, e.st, e.fl, e.pc, e.sc, e.fc, e.to);
            end
            k++;
        end
    endtask

    task automatic test_stall_priority();
        exp_t e;
        int   k = 0;
        row(1, 4'b1010, 0, 0, 32'h0, 0, 6'b011111, 0, 32'h0);
        row(1, 4'b1010, 0, 0, 32'h0, 0, 6'b011111, 0, 32'h0);
        row(1, 4'b0010, 0, 0, 32'h0, 0, 6'b000111, 0, 32'h0);
        row(1, 4'b0001, 0, 0, 32'h0, 0, 6'b000011, 0, 32'h0);
        row(1, 4'b0111, 0, 0, 32'h0, 0, 6'b001111, 0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0, 0, 6'b000000, 0, 32'h0);
        while (sq.size() != 0) begin
            @(posedge clk); #1; apply(sq.pop_front());
            @(negedge clk); e = eq.pop_front(); n_tests++;
            if ({stall, flush, new_pc, stall_cycles, flush_count, stall_timeout} !== e) begin
                n_fail++;
                $display("FAIL priority[%0d]: got stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b, want stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b",
                         k, stall, flush, new_pc, stall_cycles, flush_count, stall_timeout, e.st, e.fl, e.pc, e.sc, e.fc, e.to);
            end
            k++;
        end
    endtask

    task automatic test_exception_drain();
        exp_t e;
        int   k = 0;
        row(1, 4'b0100, 1, 0, 32'hDEAD_BEEF, 0, 6'h00,     1, 32'h20);
        row(1, 4'b0100, 1, 0, 32'hDEAD_BEEF, 0, 6'b001111, 0, 32'h0);
        row(1, 4'b0100, 1, 1, 32'hDEAD_BEEF, 0, 6'b001111, 0, 32'h0);
        row(1, 4'b0100, 1, 0, 32'hDEAD_BEEF, 0, 6'h00,     1, 32'h20);
        row(1, 4'b0000, 0, 0, 32'h0,         0, 6'h00,     0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0,         0, 6'h00,     0, 32'h0);
        while (sq.size() != 0) begin
            @(posedge clk); #1; apply(sq.pop_front());
            @(negedge clk); e = eq.pop_front(); n_tests++;
            if ({stall, flush, new_pc, stall_cycles, flush_count, stall_timeout} !== e) begin
                n_fail++;
                $display("FAIL exc_drain[%0d]: got stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b, want stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b",
                         k, stall, flush, new_pc, stall_cycles, flush_count, stall_timeout, e.st, e.fl, e.pc, e.sc, e.fc, e.to);
            end
            k++;
        end
    endtask

    task automatic test_eret_reset();
        exp_t e;
        int   k = 0;
        row(1, 4'b0000, 1, 1, 32'h8000_0100, 0, 6'h00, 1, 32'h8000_0100);
        row(0, 4'b0000, 1, 1, 32'h8000_0100, 0, 6'h00, 0, 32'h0);
        row(1, 4'b0000, 1, 0, 32'h8000_0100, 0, 6'h00, 1, 32'h20);
        row(1, 4'b0000, 0, 0, 32'h0,         0, 6'h00, 0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0,         0, 6'h00, 0, 32'h0);
        while (sq.size() != 0) begin
            @(posedge clk); #1; apply(sq.pop_front());
            @(negedge clk); e = eq.pop_front(); n_tests++;
            if ({stall, flush, new_pc, stall_cycles, flush_count, stall_timeout} !== e) begin
                n_fail++;
                $display("FAIL eret_reset[%0d]: got stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b, want stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b",
                         k, stall, flush, new_pc, stall_cycles, flush_count, stall_timeout, e.st, e.fl, e.pc, e.sc, e.fc, e.to);
            end
            k++;
        end
    endtask

    task automatic test_watchdog();
        exp_t e;
        int   k = 0;
        for (int i = 0; i < 7; i++) row(1, 4'b0001, 0, 0, 32'h0, 0, 6'b000011, 0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0);
        for (int i = 0; i < 8; i++) row(1, 4'b0001, 0, 0, 32'h0, 0, 6'b000011, 0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0, 1, 6'h00, 0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0);
        while (sq.size() != 0) begin
            @(posedge clk); #1; apply(sq.pop_front());
            @(negedge clk); e = eq.pop_front(); n_tests++;
            if ({stall, flush, new_pc, stall_cycles, flush_count, stall_timeout} !== e) begin
                n_fail++;
                $display("FAIL watchdog[%0d]: got stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b, want stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b",
                         k, stall, flush, new_pc, stall_cycles, flush_count, stall_timeout, e.st, e.fl, e.pc, e.sc, e.fc, e.to);
            end
            k++;
        end
    endtask

    task automatic test_counter_wrap();
        exp_t e;
        int   k = 0;
        row(1, 4'b0000, 0, 0, 32'h0, 1, 6'h00, 0, 32'h0);
        row(1, 4'b0000, 1, 0, 32'h0, 0, 6'h00, 1, 32'h20);
        row(1, 4'b0000, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0, 0, 6'h00, 0, 32'h0);
        for (int i = 0; i < 16; i++) row(1, 4'b0001, 0, 0, 32'h0, 0, 6'b000011, 0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0, 0, 6'h00,     0, 32'h0);
        row(1, 4'b0001, 0, 0, 32'h0, 0, 6'b000011, 0, 32'h0);
        row(1, 4'b0001, 1, 0, 32'h0, 1, 6'h00,     1, 32'h20);
        row(1, 4'b0001, 0, 0, 32'h0, 1, 6'b000011, 0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0, 0, 6'h00,     0, 32'h0);
        row(1, 4'b0000, 0, 0, 32'h0, 0, 6'h00,     0, 32'h0);
        while (sq.size() != 0) begin
            @(posedge clk); #1; apply(sq.pop_front());
            @(negedge clk); e = eq.pop_front(); n_tests++;
            if ({stall, flush, new_pc, stall_cycles, flush_count, stall_timeout} !== e) begin
                n_fail++;
                $display("FAIL cnt_wrap[%0d]: got stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b, want stall=%h flush=%b pc=%h sc=%0d fc=%0d to=%b",
                         k, stall, flush, new_pc, stall_cycles, flush_count, stall_timeout, e.st, e.fl, e.pc, e.sc, e.fc, e.to);
            end
            k++;
        end
    endtask

    initial begin
        rst          = 1'b0;
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        excp_valid   = 1'b0;
        excp_eret    = 1'b0;
        epc_i        = 32'h0;
        cnt_clr      = 1'b0;

        test_reset();
        test_stall_priority();
        test_exception_drain();
        test_eret_reset();
        test_watchdog();
        test_counter_wrap();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
